// File: rtl/rv_pkg.sv
// Shared RISC-V register-file types and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bundle of the scoreboarded register file.
// Latency: n/a (wires only).
// Backpressure: stall is advisory; issue is not gated by the register file.
// master: decode + writeback drivers; slave: the register file itself.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                RegWrite;
    logic [AW-1:0]       Rd;
    logic [XLEN-1:0]     Write_data;
    logic [NRD*AW-1:0]   Rs;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                stall;
    logic [NRD-1:0]      rs_en;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output RegWrite, Rd, Write_data, Rs, issue_valid, issue_rd, rs_en,
        input  read_data, rs_busy, stall, busy_vec
    );

    modport slave (
        input  RegWrite, Rd, Write_data, Rs, issue_valid, issue_rd, rs_en,
        output read_data, rs_busy, stall, busy_vec
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, per-port hazard flags.
// Latency: busy bits update on the clk edge; rs_busy/stall are combinational.
// Backpressure: stall is an output only; a set during stall is still honoured.
// Ports: clk/reset, writeback (RegWrite/Rd), issue (issue_valid/issue_rd),
//        read addresses + per-port bypass hits, rs_en mask -> rs_busy, stall, busy_vec.
module regfile_sb_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [AW-1:0]     Rd,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NRD*AW-1:0] Rs,
    input  logic [NRD-1:0]    bypass,
    input  logic [NRD-1:0]    rs_en,
    output logic [NRD-1:0]    rs_busy,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Set beats clear: the newly issued instruction is the youngest owner.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREGS; r++) begin
            if (issue_valid && issue_rd == AW'(r)) begin
                busy_nxt[r] = 1'b1;
            end else if (RegWrite && Rd == AW'(r)) begin
                busy_nxt[r] = 1'b0;
            end
            if (ZERO_REG != 0 && r == REG_ZERO) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

    // A same-cycle writeback to the operand satisfies it, so bypass masks the hazard.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rs_busy[i] = busy[Rs[i*AW +: AW]] & ~bypass[i];
        end
    end

    assign stall    = |(rs_busy & rs_en);
    assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and busy-bit scoreboard.
// Latency: reads combinational (zero cycles); writes/busy updates on the clk edge.
// Backpressure: stall flags RAW hazards to decode; issue is never blocked here.
// Ports: clk, reset (async active-low), bus (slave side of regfile_sb_if).
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [XLEN-1:0] mem [NREGS];
    logic [NRD-1:0]  bypass;
    logic            wr_ok;

    // Writes to the hardwired zero register are dropped.
    assign wr_ok = bus.RegWrite && !(ZERO_EN && bus.Rd == AW'(REG_ZERO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.Rd] <= bus.Write_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;

        assign addr = bus.Rs[i*AW +: AW];
        // Reset blocks writes, so it also blocks forwarding of Write_data.
        assign bypass[i] = reset && wr_ok && (bus.Rd == addr);

        always_comb begin
            rdata = mem[addr];
            if (bypass[i]) begin
                rdata = bus.Write_data;
            end else if (ZERO_EN && addr == AW'(REG_ZERO)) begin
                rdata = '0;
            end
        end

        assign bus.read_data[i*XLEN +: XLEN] = rdata;
    end

    regfile_sb_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .RegWrite    (bus.RegWrite),
        .Rd          (bus.Rd),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .Rs          (bus.Rs),
        .bypass      (bypass),
        .rs_en       (bus.rs_en),
        .rs_busy     (bus.rs_busy),
        .stall       (bus.stall),
        .busy_vec    (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: stimulus pushes expected outputs,
// the negedge monitor pops and compares every field.
module tb_regfile_sb;
    import rv_pkg::*;

    logic clk;
    logic reset;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rsb;
        logic        st;
        logic [31:0] bv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.name, ".rd0"},   bus.read_data[31:0],  e.rd0);
            cmp({e.name, ".rd1"},   bus.read_data[63:32], e.rd1);
            cmp({e.name, ".rsb"},   32'(bus.rs_busy),     32'(e.rsb));
            cmp({e.name, ".stall"}, 32'(bus.stall),       32'(e.st));
            cmp({e.name, ".bvec"},  bus.busy_vec,         e.bv);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input reg_addr_t rd, input xlen_t wd,
                         input logic iv, input reg_addr_t ird,
                         input reg_addr_t rs0, input reg_addr_t rs1, input logic [1:0] en);
        bus.RegWrite    = rw;
        bus.Rd          = rd;
        bus.Write_data  = wd;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.Rs          = {rs1, rs0};
        bus.rs_en       = en;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic [1:0] rsb, input logic st, input logic [31:0] bv);
        exp_t e;
        e.name = nm; e.rd0 = rd0; e.rd1 = rd1; e.rsb = rsb; e.st = st; e.bv = bv;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);

        // In reset: write/issue attempts must neither forward nor mark busy.
        step(); drive(1, 5, 32'hFFFF_FFFF, 1, 5, 5, 5, 2'b11);
        expect_out("rst_hold", 0, 0, 2'b00, 0, 0);

        step(); reset = 1'b1; drive(0, 0, 0, 0, 0, 5, 5, 2'b11);
        expect_out("rst_rel", 0, 0, 2'b00, 0, 0);

        step(); drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b11);
        expect_out("wr_x5", 0, 0, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 5, 0, 2'b11);
        expect_out("rd_x5", 32'hDEAD_BEEF, 0, 2'b00, 0, 0);

        // Register zero: write dropped, never forwarded, never busy.
        step(); drive(1, 0, 32'h0000_1234, 1, 0, 0, 0, 2'b11);
        expect_out("wr_x0", 0, 0, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 5, 2'b11);
        expect_out("rd_x0", 0, 32'hDEAD_BEEF, 2'b00, 0, 0);

        // Same-cycle bypass on both ports, then the stored value.
        step(); drive(1, 7, 32'hA5A5_0001, 0, 0, 7, 7, 2'b11);
        expect_out("byp_x7", 32'hA5A5_0001, 32'hA5A5_0001, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 7, 7, 2'b11);
        expect_out("mem_x7", 32'hA5A5_0001, 32'hA5A5_0001, 2'b00, 0, 0);

        // RAW hazard on x3.
        step(); drive(0, 0, 0, 1, 3, 3, 3, 2'b10);
        expect_out("haz_iss", 0, 0, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 7, 3, 2'b10);
        expect_out("haz_n1", 32'hA5A5_0001, 0, 2'b10, 1, 32'h0000_0008);
        step(); drive(0, 0, 0, 0, 0, 7, 3, 2'b01);
        expect_out("haz_mask", 32'hA5A5_0001, 0, 2'b10, 0, 32'h0000_0008);
        step(); drive(1, 3, 32'h0000_0333, 0, 0, 7, 3, 2'b10);
        expect_out("haz_wb", 32'hA5A5_0001, 32'h0000_0333, 2'b00, 0, 32'h0000_0008);
        step(); drive(0, 0, 0, 0, 0, 7, 3, 2'b10);
        expect_out("haz_clr", 32'hA5A5_0001, 32'h0000_0333, 2'b00, 0, 0);

        // Set/clear collision on x9: set wins, data still written.
        step(); drive(0, 0, 0, 1, 9, 9, 9, 2'b11);
        expect_out("col_iss", 0, 0, 2'b00, 0, 0);
        step(); drive(1, 9, 32'h0909_0909, 1, 9, 9, 9, 2'b11);
        expect_out("col_same", 32'h0909_0909, 32'h0909_0909, 2'b00, 0, 32'h0000_0200);
        step(); drive(0, 0, 0, 0, 0, 9, 9, 2'b11);
        expect_out("col_after", 32'h0909_0909, 32'h0909_0909, 2'b11, 1, 32'h0000_0200);
        step(); drive(1, 9, 32'h0909_0909, 0, 0, 9, 9, 2'b11);
        expect_out("clr_x9", 32'h0909_0909, 32'h0909_0909, 2'b00, 0, 32'h0000_0200);

        // Build busy_vec = 0xF0 with x4 = 5.
        step(); drive(1, 4, 32'h0000_0005, 0, 0, 4, 9, 2'b11);
        expect_out("wr_x4", 32'h0000_0005, 32'h0909_0909, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 1, 4, 4, 9, 2'b11);
        expect_out("iss4", 32'h0000_0005, 32'h0909_0909, 2'b00, 0, 0);
        step(); drive(0, 0, 0, 1, 5, 4, 9, 2'b11);
        expect_out("iss5", 32'h0000_0005, 32'h0909_0909, 2'b01, 1, 32'h0000_0010);
        step(); drive(0, 0, 0, 1, 6, 4, 9, 2'b11);
        expect_out("iss6", 32'h0000_0005, 32'h0909_0909, 2'b01, 1, 32'h0000_0030);
        step(); drive(0, 0, 0, 1, 7, 4, 9, 2'b11);
        expect_out("iss7", 32'h0000_0005, 32'h0909_0909, 2'b01, 1, 32'h0000_0070);
        step(); drive(0, 0, 0, 0, 0, 4, 9, 2'b11);
        expect_out("bv_f0", 32'h0000_0005, 32'h0909_0909, 2'b01, 1, 32'h0000_00F0);

        // Asynchronous reset between edges: cleared before the next posedge.
        step(); reset = 1'b0;
        expect_out("arst", 0, 0, 2'b00, 0, 0);
        step(); reset = 1'b1;
        expect_out("post_arst", 0, 0, 2'b00, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
